// File: rtl/iob_clint_pkg.sv
// iob_clint_pkg: CLINT register map, host command op codes and FSM encodings
// shared by the CLINT register file and the host-side IOb initiator.
package iob_clint_pkg;

    localparam logic [15:0] MSIP_BASE     = 16'h0000;
    localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
    localparam logic [15:0] MTIME_LO      = 16'hBFF8;
    localparam logic [15:0] MTIME_HI      = 16'hBFFC;

    typedef enum logic [1:0] {
        OP_SET_MSIP    = 2'b00,
        OP_CLR_MSIP    = 2'b01,
        OP_WR_MTIMECMP = 2'b10,
        OP_RD_MTIME    = 2'b11
    } cmd_op_t;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_WAIT = 2'd1,
        SEQ_NEXT = 2'd2,
        SEQ_DONE = 2'd3
    } seq_state_t;

    typedef enum logic [1:0] {
        XFER_IDLE  = 2'd0,
        XFER_ISSUE = 2'd1,
        XFER_RWAIT = 2'd2
    } xfer_state_t;

endpackage

// File: rtl/iob_clint_host_xfer.sv
// iob_clint_host_xfer: runs exactly one IOb transfer at a time. The request
// is latched on start_i and held stable until the slave accepts it; a read
// then waits for rvalid. done_o pulses in the cycle the transfer completes.
module iob_clint_host_xfer
    import iob_clint_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic                start_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic                we_i,
    output logic                done_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                iob_avalid_o,
    output logic [ADDR_W-1:0]   iob_addr_o,
    output logic [DATA_W-1:0]   iob_wdata_o,
    output logic [DATA_W/8-1:0] iob_wstrb_o,
    input  logic                iob_rvalid_i,
    input  logic [DATA_W-1:0]   iob_rdata_i,
    input  logic                iob_ready_i
);

    xfer_state_t       state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic [DATA_W-1:0] rdata_q;

    // Transfer engine: latch request, hold it through ISSUE, collect read data in RWAIT.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= XFER_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                XFER_IDLE: begin
                    if (start_i) begin
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        we_q    <= we_i;
                        state_q <= XFER_ISSUE;
                    end
                end
                XFER_ISSUE: begin
                    if (iob_ready_i) begin
                        state_q <= we_q ? XFER_IDLE : XFER_RWAIT;
                    end
                end
                XFER_RWAIT: begin
                    if (iob_rvalid_i) begin
                        rdata_q <= iob_rdata_i;
                        state_q <= XFER_IDLE;
                    end
                end
                default: state_q <= XFER_IDLE;
            endcase
        end
    end

    assign done_o       = ((state_q == XFER_ISSUE) && iob_ready_i && we_q) ||
                          ((state_q == XFER_RWAIT) && iob_rvalid_i);
    assign rdata_o      = rdata_q;
    assign iob_avalid_o = (state_q == XFER_ISSUE);
    assign iob_addr_o   = addr_q;
    assign iob_wdata_o  = wdata_q;
    assign iob_wstrb_o  = (iob_avalid_o && we_q) ? '1 : '0;

endmodule

// File: rtl/iob_clint_host.sv
// iob_clint_host: turns one management command into the IOb transfer
// sequence the CLINT needs (msip set/clear, glitch-free mtimecmp update,
// tear-free mtime read). Reset deassertion is expected to be synchronised
// upstream.
module iob_clint_host
    import iob_clint_pkg::*;
#(
    parameter  int ADDR_W    = 16,
    parameter  int DATA_W    = 32,
    parameter  int N_CORES   = 1,
    parameter  int MAX_RETRY = 4,
    localparam int HART_W    = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [1:0]          cmd_op_i,
    input  logic [HART_W-1:0]   cmd_hart_i,
    input  logic [63:0]         cmd_data_i,
    output logic                rsp_valid_o,
    output logic                rsp_err_o,
    output logic [63:0]         rsp_data_o,
    output logic                iob_avalid_o,
    output logic [ADDR_W-1:0]   iob_addr_o,
    output logic [DATA_W-1:0]   iob_wdata_o,
    output logic [DATA_W/8-1:0] iob_wstrb_o,
    input  logic                iob_rvalid_i,
    input  logic [DATA_W-1:0]   iob_rdata_i,
    input  logic                iob_ready_i
);

    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    if (DATA_W != 32) begin : g_data_w_check
        $error("iob_clint_host: only DATA_W = 32 is supported");
    end

    seq_state_t         state_q;
    cmd_op_t            op_q;
    logic [HART_W-1:0]  hart_q;
    logic [63:0]        data_q;
    logic [1:0]         step_q;
    logic [RETRY_W-1:0] retry_q;
    logic [DATA_W-1:0]  h0_q;
    logic [DATA_W-1:0]  lo_q;
    logic               rsp_valid_q;
    logic               rsp_err_q;
    logic [63:0]        rsp_data_q;

    logic               accept;
    logic               bad_hart;
    logic               last_step;
    logic               mismatch;
    logic [RETRY_W-1:0] retry_inc;
    logic               retry_left;
    logic               restart;
    logic               xfer_start;
    logic               xfer_done;
    logic [DATA_W-1:0]  xfer_rdata;

    cmd_op_t            sel_op;
    logic [HART_W-1:0]  sel_hart;
    logic [63:0]        sel_data;
    logic [1:0]         sel_step;
    logic [ADDR_W-1:0]  hart_off;
    logic [ADDR_W-1:0]  xfer_addr;
    logic [DATA_W-1:0]  xfer_wdata;
    logic               xfer_we;

    assign accept     = cmd_valid_i && (state_q == SEQ_IDLE);
    assign bad_hart   = (cmd_op_t'(cmd_op_i) != OP_RD_MTIME) && (32'(cmd_hart_i) >= N_CORES);
    assign last_step  = ((op_q == OP_SET_MSIP) || (op_q == OP_CLR_MSIP)) ? (step_q == 2'd0)
                                                                         : (step_q == 2'd2);
    assign mismatch   = (xfer_rdata != h0_q);
    assign retry_inc  = retry_q + RETRY_W'(1);
    assign retry_left = (32'(retry_inc) < MAX_RETRY);
    assign restart    = (state_q == SEQ_NEXT) && (op_q == OP_RD_MTIME) && last_step &&
                        mismatch && retry_left;
    assign xfer_start = (accept && !bad_hart) ||
                        ((state_q == SEQ_NEXT) && (!last_step || restart));

    // Pick the transfer to launch: from the live command in IDLE, else the following step.
    always_comb begin
        sel_op   = op_q;
        sel_hart = hart_q;
        sel_data = data_q;
        sel_step = step_q + 2'd1;
        if (state_q == SEQ_IDLE) begin
            sel_op   = cmd_op_t'(cmd_op_i);
            sel_hart = cmd_hart_i;
            sel_data = cmd_data_i;
            sel_step = 2'd0;
        end else if (restart) begin
            sel_step = 2'd0;
        end
    end

    // Decode the selected step into an IOb address, write data and direction.
    always_comb begin
        hart_off   = ADDR_W'(sel_hart);
        xfer_addr  = '0;
        xfer_wdata = '0;
        xfer_we    = 1'b1;
        case (sel_op)
            OP_SET_MSIP: begin
                xfer_addr  = ADDR_W'(MSIP_BASE) + (hart_off << 2);
                xfer_wdata = DATA_W'(1);
            end
            OP_CLR_MSIP: begin
                xfer_addr  = ADDR_W'(MSIP_BASE) + (hart_off << 2);
                xfer_wdata = '0;
            end
            OP_WR_MTIMECMP: begin
                xfer_addr = ADDR_W'(MTIMECMP_BASE) + (hart_off << 3) +
                            ((sel_step == 2'd1) ? ADDR_W'(4) : ADDR_W'(0));
                case (sel_step)
                    2'd0:    xfer_wdata = '1;
                    2'd1:    xfer_wdata = DATA_W'(sel_data[63:32]);
                    default: xfer_wdata = DATA_W'(sel_data[31:0]);
                endcase
            end
            OP_RD_MTIME: begin
                xfer_addr = (sel_step == 2'd1) ? ADDR_W'(MTIME_LO) : ADDR_W'(MTIME_HI);
                xfer_we   = 1'b0;
            end
            default: xfer_we = 1'b1;
        endcase
    end

    // Command sequencer: step/retry bookkeeping and the registered response.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q     <= SEQ_IDLE;
            op_q        <= OP_SET_MSIP;
            hart_q      <= '0;
            data_q      <= '0;
            step_q      <= '0;
            retry_q     <= '0;
            h0_q        <= '0;
            lo_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            case (state_q)
                SEQ_IDLE: begin
                    if (accept) begin
                        op_q    <= cmd_op_t'(cmd_op_i);
                        hart_q  <= cmd_hart_i;
                        data_q  <= cmd_data_i;
                        step_q  <= 2'd0;
                        retry_q <= '0;
                        if (bad_hart) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_data_q  <= '0;
                            state_q     <= SEQ_DONE;
                        end else begin
                            state_q <= SEQ_WAIT;
                        end
                    end
                end
                SEQ_WAIT: begin
                    if (xfer_done) begin
                        state_q <= SEQ_NEXT;
                    end
                end
                SEQ_NEXT: begin
                    if (op_q == OP_RD_MTIME) begin
                        if (step_q == 2'd0) h0_q <= xfer_rdata;
                        if (step_q == 2'd1) lo_q <= xfer_rdata;
                    end
                    if (!last_step) begin
                        step_q  <= step_q + 2'd1;
                        state_q <= SEQ_WAIT;
                    end else if ((op_q == OP_RD_MTIME) && mismatch) begin
                        retry_q <= retry_inc;
                        if (retry_left) begin
                            step_q  <= 2'd0;
                            state_q <= SEQ_WAIT;
                        end else begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_data_q  <= '0;
                            state_q     <= SEQ_DONE;
                        end
                    end else begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_data_q  <= (op_q == OP_RD_MTIME) ? {xfer_rdata, lo_q} : 64'd0;
                        state_q     <= SEQ_DONE;
                    end
                end
                SEQ_DONE: begin
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    state_q     <= SEQ_IDLE;
                end
                default: state_q <= SEQ_IDLE;
            endcase
        end
    end

    iob_clint_host_xfer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_xfer (
        .clk_i        (clk_i),
        .arst_n_i     (arst_n_i),
        .start_i      (xfer_start),
        .addr_i       (xfer_addr),
        .wdata_i      (xfer_wdata),
        .we_i         (xfer_we),
        .done_o       (xfer_done),
        .rdata_o      (xfer_rdata),
        .iob_avalid_o (iob_avalid_o),
        .iob_addr_o   (iob_addr_o),
        .iob_wdata_o  (iob_wdata_o),
        .iob_wstrb_o  (iob_wstrb_o),
        .iob_rvalid_i (iob_rvalid_i),
        .iob_rdata_i  (iob_rdata_i),
        .iob_ready_i  (iob_ready_i)
    );

    assign cmd_ready_o = (state_q == SEQ_IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_data_o  = rsp_data_q;

endmodule
